// File: rtl/vaman_pkg.sv
// vaman_pkg: shared BCD types, limits and seven-segment patterns for the decade counter
package vaman_pkg;
  typedef logic [3:0] bcd_t;
  localparam bcd_t BCD_MAX = 4'd9;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  // Padded to 16 entries so any 4-bit code indexes cleanly; non-BCD codes blank the display
  localparam logic [15:0][6:0] SEG_LUT = {{6{7'h00}}, SEG_9, SEG_8, SEG_7, SEG_6, SEG_5,
                                          SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};
  function automatic logic [6:0] seg_decode(bcd_t v);
    return SEG_LUT[v];
  endfunction
endpackage

// File: rtl/bcd_state_register_if.sv
// bcd_state_register_if: decoder-facing bundle of the decade counter state register
interface bcd_state_register_if;
  import vaman_pkg::*;
  bcd_t       d;
  logic       step_clk;
  logic       hold;
  bcd_t       q;
  logic [6:0] seg;
  logic       carry;
  logic       err;
  modport master (output d, step_clk, hold, input q, seg, carry, err);
  modport slave  (input d, step_clk, hold, output q, seg, carry, err);
endinterface

// File: rtl/step_sync_edge.sv
// step_sync_edge: synchronizes a slow asynchronous clock and emits a one-cycle pulse per rising edge
module step_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic step
);
  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;
  // Flops reset high so a level already high at reset release is not seen as an edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= '1;
      hist <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], async_in};
      hist <= sync[SYNC_STAGES-1];
    end
  assign step = sync[SYNC_STAGES-1] & ~hist;
endmodule

// File: rtl/bcd_state_register.sv
// bcd_state_register: BCD state register with step sync, hold gating, carry, error flag and segment output
module bcd_state_register
  import vaman_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input logic                 clk,
  input logic                 rst_n,
  bcd_state_register_if.slave bus
);
  localparam logic [6:0] SEG_MASK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  logic step, load, valid;
  step_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (bus.step_clk),
    .step     (step)
  );
  assign load  = step & ~bus.hold;
  assign valid = bus.d <= BCD_MAX;
  // Invalid codes force 0 without a carry; err is sticky until reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.q     <= '0;
      bus.carry <= 1'b0;
      bus.err   <= 1'b0;
      bus.seg   <= SEG_0 ^ SEG_MASK;
    end else begin
      bus.q     <= load ? (valid ? bus.d : '0) : bus.q;
      bus.carry <= load & valid & (bus.q == BCD_MAX) & (bus.d == '0);
      bus.err   <= bus.err | (load & ~valid);
      bus.seg   <= seg_decode(bus.q) ^ SEG_MASK;
    end
endmodule

// File: tb/tb_bcd_state_register.sv
// tb_bcd_state_register: vector, random and closed-loop checks of the BCD state register
module tb_bcd_state_register;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cmp = 0;
  int fails = 0;
  int cur_q = 0;
  int m_err = 0;
  logic [6:0] seg_hi [10];
  typedef struct {int d; int h; int q; int c; int e;} vec_t;
  vec_t tbl [11];

  bcd_state_register_if bus ();
  bcd_state_register #(.SYNC_STAGES(2), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    cmp++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic int seg_exp(input int v);
    return int'(~seg_hi[v] & 7'h7F);
  endfunction

  task automatic do_reset(input bit sc);
    bus.step_clk = sc;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    cur_q = 0;
    m_err = 0;
  endtask

  // One full step_clk period with timing checks against supplied expectations
  task automatic do_step(input string tag, input int dv, input int hv, input int eq, input int ec, input int ee);
    bus.d = 4'(dv);
    bus.hold = hv[0];
    bus.step_clk = 1'b1;
    tick();
    tick();
    chk({tag, " q_before_latency"}, int'(bus.q), cur_q);
    tick();
    chk({tag, " q"}, int'(bus.q), eq);
    chk({tag, " carry"}, int'(bus.carry), ec);
    tick();
    chk({tag, " carry_one_cycle"}, int'(bus.carry), 0);
    chk({tag, " seg"}, int'(bus.seg), seg_exp(eq));
    chk({tag, " err"}, int'(bus.err), ee);
    cur_q = eq;
    bus.step_clk = 1'b0;
    repeat (4) tick();
  endtask

  // Reference model: plain rules for one accepted or held step
  task automatic model_step(input string tag, input int dv, input int hv);
    int nq;
    int c;
    nq = cur_q;
    c = 0;
    if (hv == 0) begin
      nq = (dv > 9) ? 0 : dv;
      c = (cur_q == 9 && dv == 0) ? 1 : 0;
      if (dv > 9) m_err = 1;
    end
    do_step(tag, dv, hv, nq, c, m_err);
  endtask

  initial begin
    seg_hi = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    tbl = '{'{4, 0, 4, 0, 0}, '{9, 0, 9, 0, 0}, '{0, 0, 0, 1, 0}, '{1, 0, 1, 0, 0},
            '{7, 1, 1, 0, 0}, '{7, 1, 1, 0, 0}, '{7, 1, 1, 0, 0}, '{7, 0, 7, 0, 0},
            '{9, 0, 9, 0, 0}, '{12, 0, 0, 0, 1}, '{3, 0, 3, 0, 1}};
    bus.d = 4'd5;
    bus.hold = 1'b0;
    do_reset(1'b1);
    chk("reset q", int'(bus.q), 0);
    chk("reset seg", int'(bus.seg), 7'h40);
    chk("reset carry", int'(bus.carry), 0);
    chk("reset err", int'(bus.err), 0);
    repeat (5) tick();
    chk("no step while high at release", int'(bus.q), 0);
    bus.step_clk = 1'b0;
    repeat (5) tick();
    chk("no step on falling edge", int'(bus.q), 0);
    for (int i = 0; i < 11; i++)
      do_step($sformatf("vec%0d", i), tbl[i].d, tbl[i].h, tbl[i].q, tbl[i].c, tbl[i].e);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset q", int'(bus.q), 0);
    chk("async reset err", int'(bus.err), 0);
    chk("async reset seg", int'(bus.seg), 7'h40);
    tick();
    rst_n = 1'b1;
    bus.step_clk = 1'b0;
    tick();
    cur_q = 0;
    m_err = 0;
    repeat (4) tick();
    for (int i = 0; i < 40; i++) begin
      int dv;
      int hv;
      dv = ($urandom_range(0, 1) == 0) ? (cur_q + 1) % 10 : int'($urandom_range(0, 10));
      hv = ($urandom_range(0, 3) == 0) ? 1 : 0;
      model_step($sformatf("rnd%0d", i), dv, hv);
    end
    do_reset(1'b0);
    repeat (4) tick();
    for (int i = 0; i < 25; i++)
      model_step($sformatf("loop%0d", i + 1), (cur_q + 1) % 10, 0);
    chk("loop final q", int'(bus.q), 5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
    $finish;
  end
endmodule

// File: doc/bcd_state_register.md
# bcd_state_register

Four-bit state register stage that closes the loop of the board's decade counter. It captures the 4-bit next-state code from the upstream incrementing decoder on each rising edge of that decoder's slow divided clock. It feeds the stored state back to the decoder's inputs and drives a registered seven-segment display of the current digit. The block behaves like a bank of four 7474 D flip-flops with async clear, clocked synchronously: the slow clock is treated as a sampled step request, never as a clock.

## Interface
- `SYNC_STAGES`, 2, number of synchronizer flops on `step_clk` (minimum 2)
- `SEG_ACTIVE_LOW`, 1, 1 = `seg` outputs inverted for common-anode display
- `clk`  in  1  system clock (Sys_Clk0 domain)
- `rst_n`  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
- `d`  in  4  next-state code from incrementing decoder, bit 0 = LSB
- `step_clk`  in  1  slow divided clock from decoder; asynchronous to `clk`
- `hold`  in  1  1 = ignore step edges, keep `q`
- `q`  out  4  current BCD state, fed back to decoder inputs
- `seg`  out  7  segments {g,f,e,d,c,b,a}
- `carry`  out  1  one-`clk` pulse on 9→0 rollover
- `err`  out  1  sticky: a non-BCD code (>9) was presented at a load

## Operation
- `step_clk` passes through `SYNC_STAGES` flops, then one history flop. A step is `sync_out & ~hist`.
- Synchronizer and history flops reset to 1. A `step_clk` already high at reset release produces no step. The first step requires a low→high transition.
- On a step with `hold`=0:
  - d ≤ 9: `q` ← d.
  - d > 9: `q` ← 0 and `err` ← 1.
- On a step with `hold`=1: `q` is unchanged, `carry` stays 0, and the step is discarded, not queued.
- `carry` is 1 for exactly the cycle after a load where old `q`=9 and new `q`=0.
- `carry` does not fire for a forced 0 caused by an invalid code.
- `err` clears only on reset.
- `seg` is a registered decode of `q`. Active-high patterns for 0–9 (a–g, LSB=a): 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F hex. `SEG_ACTIVE_LOW`=1 inverts all 7 bits.
- Reset values:
  - `q`=0, `carry`=0, `err`=0.
  - `seg` = the digit-0 pattern: 3F active-high, 40 active-low.

## Timing
- The example uses `SYNC_STAGES`=2 and `step_clk` sampled high first at `clk` edge N.
  - Synchronizer output goes high at N+1.
  - Step is decoded combinationally in cycle N+1→N+2.
  - `q` and `carry` update at edge N+2.
  - `seg` updates at N+3.
- General load latency: `SYNC_STAGES` clk edges after the first high sample.
- `step_clk` high or low time below `SYNC_STAGES`+1 `clk` periods is unsupported. The decoder's divider guarantees ~20M cycles.
- `hold` is sampled in the same cycle the step is decoded.
- A step and `hold` changing in the same cycle use the `hold` value registered at that edge.
- `d` must be stable for the step cycle; it comes from logic combinational on `q` and is stable between steps.
- Reset mid-operation clears everything immediately and asynchronously. After deassertion, no step occurs until `step_clk` is seen low then high.
- `carry` is never longer than one `clk` cycle, including when steps occur back-to-back.

## Structure
- Shared package `vaman_pkg` holds:
  - the 7-bit seven-segment patterns for 0–9 as constants;
  - `BCD_MAX` = 4'd9;
  - a 4-bit `bcd_t` typedef.
- Sub-module `step_sync_edge` covers the synchronizer chain, history flop and one-cycle step pulse output. It is parameterized by `SYNC_STAGES` and reused for other slow-clock consumers.
- The top level holds the `q` register, hold gating, range check, carry/err logic and seg register.

## Test plan
- Reset: assert `rst_n`=0 with `step_clk`=1, then release → `q`=0, `seg`=7'h40, `carry`=0, `err`=0. No load until `step_clk` goes 0 then 1.
- Normal load: d=4, `step_clk` rises → `q`=4 exactly 2 clk edges after first high sample, `seg`=7'h19 one edge later.
- Rollover: `q`=9, d=0, step → `q`=0, `carry` high for exactly one cycle. Then d=1, step → `q`=1, `carry`=0.
- Hold: `hold`=1, d=7, three steps → `q` unchanged. Release `hold` → next step loads 7; missed steps are not replayed.
- Invalid code: d=4'hC, step → `q`=0, `carry`=0, `err`=1. `err` stays 1 through later valid loads until `rst_n` pulses.
- Closed loop with the incrementing decoder model: 25 steps from reset → `q` sequence 1..9,0,1..9,0,1..5, with `carry` pulses at steps 10 and 20 only.
